// File: rtl/video_pkg.sv
// Shared definitions for the character video path: fetch FSM states and
// the fixed geometry of a character cell.
package video_pkg;

  localparam int              ADDR_W            = 14;
  localparam int              PIXELS_PER_CHAR   = 8;
  localparam logic [13:0]     DEFAULT_VROM_BASE = 14'h2000;

  // ST_DROP is the single request-free cycle after an abandoned fetch.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RAM  = 3'd1,
    ST_ROM  = 3'd2,
    ST_DONE = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/char_shifter.sv
// Parallel-load pixel shifter with one reverse-video flag per character.
// Character 0 occupies the MSBs of both load vectors.
module char_shifter
  import video_pkg::*;
#(
  parameter int CHARS = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             load_i,
  input  logic                             shift_i,
  input  logic [CHARS*PIXELS_PER_CHAR-1:0] pix_i,
  input  logic [CHARS-1:0]                 rev_i,
  output logic                             video_o
);

  localparam int NBITS = CHARS * PIXELS_PER_CHAR;
  localparam int BW    = $clog2(PIXELS_PER_CHAR);
  localparam logic [BW-1:0] BIT_LAST = BW'(PIXELS_PER_CHAR - 1);

  logic [NBITS-1:0] shift_q, shift_d;
  logic [CHARS-1:0] rev_q, rev_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             video_q, video_d;

  // Rev flags shift once per character, so an exhausted register reads all zeros.
  always_comb begin
    shift_d = shift_q;
    rev_d   = rev_q;
    bit_d   = bit_q;
    if (load_i) begin
      shift_d = pix_i;
      rev_d   = rev_i;
      bit_d   = {BW{1'b0}};
    end else if (shift_i) begin
      shift_d = shift_q << 1'b1;
      bit_d   = bit_q + BW'(1'b1);
      if (bit_q == BIT_LAST) begin
        rev_d = rev_q << 1'b1;
      end else begin
        rev_d = rev_q;
      end
    end else begin
      shift_d = shift_q;
    end
    video_d = shift_q[NBITS-1] ^ rev_q[CHARS-1];
  end

  // Shifter state and registered pixel output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= {NBITS{1'b0}};
      rev_q   <= {CHARS{1'b0}};
      bit_q   <= {BW{1'b0}};
      video_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rev_q   <= rev_d;
      bit_q   <= bit_d;
      video_q <= video_d;
    end
  end

  assign video_o = video_q;

endmodule

// File: rtl/char_fetch_gen.sv
// Character fetch and dot generator: fetches codes and glyph rows per character
// period and shifts them out one period later. Optional cursor: CHAR_FETCH_CURSOR_EN.
module char_fetch_gen
  import video_pkg::*;
#(
  parameter int                CHARS     = 2,
  parameter int                ROM_ROWS  = 8,
  parameter logic [ADDR_W-1:0] VROM_BASE = DEFAULT_VROM_BASE
) (
  input  logic              clk16_i,
  input  logic              reset_i,
  input  logic              cclk_en_i,
  input  logic              pixel_en_i,
  input  logic [ADDR_W-1:0] ma_i,
  input  logic [4:0]        ra_i,
  input  logic              de_i,
  input  logic              gfx_i,
`ifdef CHAR_FETCH_CURSOR_EN
  input  logic              cursor_i,
`endif
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              ack_i,
  input  logic [7:0]        data_i,
  output logic              video_o,
  output logic              underrun_o
);

  localparam int IW    = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int RW    = $clog2(ROM_ROWS);
  localparam int NBITS = CHARS * PIXELS_PER_CHAR;
  localparam logic [IW-1:0]     LAST_IDX = IW'(CHARS - 1);
  localparam logic [ADDR_W-1:0] CHARS_A  = ADDR_W'(CHARS);
  localparam logic [4:0]        RA_ROWS  = 5'(ROM_ROWS);

  fetch_state_t            state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [ADDR_W-1:0]       ma_q, ma_d;
  logic [4:0]              ra_q, ra_d;
  logic                    de_q, de_d;
  logic                    gfx_q, gfx_d;
  logic [CHARS-1:0][7:0]   code_q, code_d;
  logic [CHARS-1:0][7:0]   glyph_q, glyph_d;
  logic                    req_q, req_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    und_q, und_d;
  logic                    load_s, load_blank_s, blank_s;
  logic [NBITS-1:0]        load_pix_s;
  logic [CHARS-1:0]        load_rev_s;
`ifdef CHAR_FETCH_CURSOR_EN
  logic                    cur_q, cur_d;
`endif

  assign blank_s = !de_q || (ra_q >= RA_ROWS);

  // Fetch FSM; a new period always wins over a same-cycle acknowledge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ma_d         = ma_q;
    ra_d         = ra_q;
    de_d         = de_q;
    gfx_d        = gfx_q;
    code_d       = code_q;
    glyph_d      = glyph_q;
    und_d        = und_q;
    load_s       = 1'b0;
    load_blank_s = 1'b1;
`ifdef CHAR_FETCH_CURSOR_EN
    cur_d        = cur_q;
`endif
    if (cclk_en_i) begin
      ma_d   = ma_i;
      ra_d   = ra_i;
      de_d   = de_i;
      gfx_d  = gfx_i;
      idx_d  = {IW{1'b0}};
      load_s = 1'b1;
`ifdef CHAR_FETCH_CURSOR_EN
      cur_d  = cursor_i;
`endif
      case (state_q)
        ST_RAM, ST_ROM: begin
          und_d        = 1'b1;
          state_d      = ST_DROP;
          load_blank_s = 1'b1;
        end
        ST_DONE: begin
          state_d      = ST_RAM;
          load_blank_s = blank_s;
        end
        default: begin
          state_d      = ST_RAM;
          load_blank_s = 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        ST_RAM: begin
          if (ack_i) begin
            code_d[idx_q] = data_i;
            state_d       = ST_ROM;
          end else begin
            state_d = ST_RAM;
          end
        end
        ST_ROM: begin
          if (ack_i) begin
            glyph_d[idx_q] = data_i;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IW'(1'b1);
              state_d = ST_RAM;
            end
          end else begin
            state_d = ST_ROM;
          end
        end
        ST_DROP: state_d = ST_RAM;
        default: state_d = state_q;
      endcase
    end

    req_d = (state_d == ST_RAM) || (state_d == ST_ROM);
    case (state_d)
      ST_RAM:  addr_d = ma_d * CHARS_A + ADDR_W'(idx_d);
      ST_ROM:  addr_d = VROM_BASE | {{(ADDR_W-8-RW){1'b0}}, gfx_d,
                                     code_d[idx_d][6:0], ra_d[RW-1:0]};
      default: addr_d = {ADDR_W{1'b0}};
    endcase
  end

  // Shift-register load image from the completed buffers.
  always_comb begin
    load_pix_s = {NBITS{1'b0}};
    load_rev_s = {CHARS{1'b0}};
    for (int c = 0; c < CHARS; c++) begin
      load_pix_s[NBITS-1-PIXELS_PER_CHAR*c -: PIXELS_PER_CHAR] = glyph_q[c];
      load_rev_s[CHARS-1-c] = code_q[c][7];
    end
`ifdef CHAR_FETCH_CURSOR_EN
    load_rev_s[CHARS-1] = load_rev_s[CHARS-1] ^ cur_q;
`endif
    if (load_blank_s) begin
      load_pix_s = {NBITS{1'b0}};
      load_rev_s = {CHARS{1'b0}};
    end else begin
      load_rev_s = load_rev_s;
    end
  end

  // Fetch state, latched CRTC values, buffers and bus outputs.
  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= {IW{1'b0}};
      ma_q    <= {ADDR_W{1'b0}};
      ra_q    <= 5'd0;
      de_q    <= 1'b0;
      gfx_q   <= 1'b0;
      code_q  <= {CHARS{8'h00}};
      glyph_q <= {CHARS{8'h00}};
      req_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      und_q   <= 1'b0;
`ifdef CHAR_FETCH_CURSOR_EN
      cur_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ma_q    <= ma_d;
      ra_q    <= ra_d;
      de_q    <= de_d;
      gfx_q   <= gfx_d;
      code_q  <= code_d;
      glyph_q <= glyph_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      und_q   <= und_d;
`ifdef CHAR_FETCH_CURSOR_EN
      cur_q   <= cur_d;
`endif
    end
  end

  char_shifter #(.CHARS(CHARS)) u_shifter (
    .clk_i   (clk16_i),
    .rst_i   (reset_i),
    .load_i  (load_s),
    .shift_i (pixel_en_i),
    .pix_i   (load_pix_s),
    .rev_i   (load_rev_s),
    .video_o (video_o)
  );

  assign req_o      = req_q;
  assign addr_o     = addr_q;
  assign underrun_o = und_q;

endmodule
